// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg: shared types and phase-length helpers for the loop sequencer.
//   state_t   - sequencer FSM state encoding
//   load_len  - LOAD phase length in cycles (ARRAY_N)
//   drain_len - DRAIN phase length in cycles (2*ARRAY_N-1)
package loop_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int unsigned load_len(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned drain_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/loop_sequencer_seq_counter.sv
// seq_counter: enabled CNT_W-bit up-counter that wraps to 0 after reaching 'last'.
//   clk   - clock (rising edge)
//   rstn  - synchronous active-low reset, clears count
//   clr   - synchronous clear to 0 (priority over en)
//   en    - advance by one this cycle
//   last  - terminal value; the count after it is 0
//   count - current value
//   tc    - high while count == last
module seq_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  assign tc = (count == last);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// loop_sequencer: tile-loop controller for an ARRAY_N x ARRAY_N systolic array.
// Per tile it runs LOAD (ARRAY_N cycles of w_load), FEED (cfg_k cycles of
// a_feed), DRAIN (2*ARRAY_N-1 cycles, psum_store in the last ARRAY_N), with
// tile_col as the inner loop and tile_row as the outer loop.
// Ports:
//   clk, rstn                    - clock, synchronous active-low reset
//   start                        - job request, accepted only in IDLE
//   stall                        - (only with LOOP_SEQ_STALL_EN) freeze everything
//   cfg_rows, cfg_cols, cfg_k    - job configuration, latched at start
//   busy, done                   - not-IDLE flag, one-cycle completion pulse
//   w_load, a_feed               - array weight-load / activation-feed enables
//   acc_clear, psum_store        - accumulator clear / partial-sum store strobes
//   tile_row, tile_col           - current tile indices
//   phase_cnt                    - cycle index within the current phase
// Optional feature macro: LOOP_SEQ_STALL_EN (adds the stall input).
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int unsigned ARRAY_N = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
`ifdef LOOP_SEQ_STALL_EN
  input  logic             stall,
`endif
  input  logic [CNT_W-1:0] cfg_rows,
  input  logic [CNT_W-1:0] cfg_cols,
  input  logic [CNT_W-1:0] cfg_k,
  output logic             busy,
  output logic             done,
  output logic             w_load,
  output logic             a_feed,
  output logic             acc_clear,
  output logic             psum_store,
  output logic [CNT_W-1:0] tile_row,
  output logic [CNT_W-1:0] tile_col,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(load_len(ARRAY_N) - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drain_len(ARRAY_N) - 1);
  // psum_store covers the final ARRAY_N cycles of DRAIN
  localparam logic [CNT_W-1:0] PSUM_FIRST = CNT_W'(drain_len(ARRAY_N) - ARRAY_N);

  state_t           state;
  logic [CNT_W-1:0] rows_q;
  logic [CNT_W-1:0] cols_q;
  logic [CNT_W-1:0] k_q;
  logic             hold;
  logic             accept;
  logic             cfg_zero;
  logic             phase_en;
  logic             drain_end;
  logic             last_tile;
  logic [CNT_W-1:0] phase_last;
  logic             phase_tc;
  logic             col_tc;
  logic             row_tc;

`ifdef LOOP_SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign accept    = !hold && (state == IDLE) && start;
  assign cfg_zero  = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_k == '0);
  assign phase_en  = !hold && ((state == LOAD) || (state == FEED) || (state == DRAIN));
  assign drain_end = !hold && (state == DRAIN) && phase_tc;
  assign last_tile = row_tc && col_tc;

  always_comb begin
    phase_last = '0;
    unique case (state)
      LOAD:    phase_last = LOAD_LAST;
      FEED:    phase_last = k_q - ONE;
      DRAIN:   phase_last = DRAIN_LAST;
      default: phase_last = '0;
    endcase
  end

  // Each phase ends on its counter's terminal value, so the wrap to 0
  // provides the zero phase_cnt on entry to the next state.
  seq_counter #(.CNT_W(CNT_W)) u_phase (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (accept),
    .en    (phase_en),
    .last  (phase_last),
    .count (phase_cnt),
    .tc    (phase_tc)
  );

  seq_counter #(.CNT_W(CNT_W)) u_col (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (accept),
    .en    (drain_end),
    .last  (cols_q - ONE),
    .count (tile_col),
    .tc    (col_tc)
  );

  seq_counter #(.CNT_W(CNT_W)) u_row (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (accept),
    .en    (drain_end && col_tc),
    .last  (rows_q - ONE),
    .count (tile_row),
    .tc    (row_tc)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      rows_q <= '0;
      cols_q <= '0;
      k_q    <= '0;
    end else if (!hold) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rows_q <= cfg_rows;
            cols_q <= cfg_cols;
            k_q    <= cfg_k;
            state  <= cfg_zero ? DONE : LOAD;
          end
        end
        LOAD:    if (phase_tc) state <= FEED;
        FEED:    if (phase_tc) state <= DRAIN;
        DRAIN:   if (phase_tc) state <= last_tile ? DONE : LOAD;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign w_load     = !hold && (state == LOAD);
  assign a_feed     = !hold && (state == FEED);
  assign acc_clear  = !hold && (state == FEED) && (phase_cnt == '0);
  assign psum_store = !hold && (state == DRAIN) && (phase_cnt >= PSUM_FIRST);

endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: scoreboard bench for loop_sequencer (ARRAY_N=4, CNT_W=16).
// Each job pushes its full expected per-cycle output trace when start is driven;
// the monitor pops and compares one entry per cycle, and checks idle outputs
// whenever the queue is empty. Stall scenario is built only with LOOP_SEQ_STALL_EN.
module tb_loop_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         w_load;
    logic         a_feed;
    logic         acc_clear;
    logic         psum_store;
    logic [W-1:0] row;
    logic [W-1:0] col;
    logic [W-1:0] phase;
  } obs_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic         stall;
  logic [W-1:0] cfg_rows, cfg_cols, cfg_k;
  logic         busy, done, w_load, a_feed, acc_clear, psum_store;
  logic [W-1:0] tile_row, tile_col, phase_cnt;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cycle = -1;
  int   stall_at = -1;
  int   stall_len = 0;
  int   restart_at = -1;
  int   rst_at = -1;

  always #5 clk = ~clk;

  loop_sequencer #(.ARRAY_N(N), .CNT_W(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
`ifdef LOOP_SEQ_STALL_EN
    .stall      (stall),
`endif
    .cfg_rows   (cfg_rows),
    .cfg_cols   (cfg_cols),
    .cfg_k      (cfg_k),
    .busy       (busy),
    .done       (done),
    .w_load     (w_load),
    .a_feed     (a_feed),
    .acc_clear  (acc_clear),
    .psum_store (psum_store),
    .tile_row   (tile_row),
    .tile_col   (tile_col),
    .phase_cnt  (phase_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Stall cycles replay the held entry with all array strobes forced low.
  task automatic push_entry(input obs_t e);
    obs_t g;
    if (exp_q.size() == stall_at) begin
      g = e;
      g.w_load = 1'b0;
      g.a_feed = 1'b0;
      g.acc_clear = 1'b0;
      g.psum_store = 1'b0;
      for (int i = 0; i < stall_len; i++) exp_q.push_back(g);
    end
    exp_q.push_back(e);
  endtask

  task automatic push_job(input int unsigned rows, input int unsigned cols, input int unsigned k);
    obs_t e;
    e = '0;
    push_entry(e);                         // cycle 0: start presented, still idle
    if (rows == 0 || cols == 0 || k == 0) begin
      e.busy = 1'b1;
      e.done = 1'b1;
      push_entry(e);
      return;
    end
    for (int unsigned r = 0; r < rows; r++) begin
      for (int unsigned c = 0; c < cols; c++) begin
        for (int unsigned p = 0; p < N; p++) begin
          e = '0;
          e.busy = 1'b1; e.w_load = 1'b1;
          e.row = W'(r); e.col = W'(c); e.phase = W'(p);
          push_entry(e);
        end
        for (int unsigned p = 0; p < k; p++) begin
          e = '0;
          e.busy = 1'b1; e.a_feed = 1'b1; e.acc_clear = (p == 0);
          e.row = W'(r); e.col = W'(c); e.phase = W'(p);
          push_entry(e);
        end
        for (int unsigned p = 0; p < 2 * N - 1; p++) begin
          e = '0;
          e.busy = 1'b1; e.psum_store = (p >= N - 1);
          e.row = W'(r); e.col = W'(c); e.phase = W'(p);
          push_entry(e);
        end
      end
    end
    e = '0;
    e.busy = 1'b1;
    e.done = 1'b1;                         // indices have wrapped back to 0
    push_entry(e);
  endtask

  task automatic monitor();
    obs_t got, e;
    string tag;
    got = {busy, done, w_load, a_feed, acc_clear, psum_store, tile_row, tile_col, phase_cnt};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tag = "trace";
    end else begin
      e = '0;
      tag = "idle";
    end
    check_eq(tag, 64'(got), 64'(e));
    if (done) done_cycle = cyc;
  endtask

  task automatic cycle_end();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_job(input int unsigned rows, input int unsigned cols, input int unsigned k,
                         input int exp_done);
    int n;
    cfg_rows = W'(rows);
    cfg_cols = W'(cols);
    cfg_k    = W'(k);
    cyc = 0;
    done_cycle = -1;
    push_job(rows, cols, k);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      start = (cyc == 0) || (cyc == restart_at);
      stall = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
      if (cyc == rst_at) rstn = 1'b0;
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        rstn = 1'b1;
        exp_q.delete();
      end
      cycle_end();
      n++;
    end
    start = 1'b0;
    stall = 1'b0;
    if (exp_q.size() > 0) begin
      check_eq("timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    check_eq("done_cycle", 64'(done_cycle), 64'(exp_done));
    for (int i = 0; i < 3; i++) cycle_end();
    stall_at = -1;
    stall_len = 0;
    restart_at = -1;
    rst_at = -1;
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b1;
    stall = 1'b0;
    cfg_rows = 16'd1;
    cfg_cols = 16'd1;
    cfg_k = 16'd3;
    @(posedge clk);
    #1;
    // reset overrides a held start
    cycle_end();
    cycle_end();
    rstn = 1'b1;
    start = 1'b0;
    cycle_end();

    run_job(1, 1, 3, 15);                  // single tile
    run_job(2, 2, 2, 53);                  // 4 tiles of 13 cycles
    run_job(1, 3, 5, 49);                  // column-only loop
    run_job(3, 1, 1, 37);                  // row-only loop, k=1
    restart_at = 6;
    run_job(1, 1, 3, 15);                  // start during FEED ignored
    run_job(1, 1, 0, 1);                   // zero k
    run_job(0, 2, 2, 1);                   // zero rows
    rst_at = 10;
    run_job(1, 1, 3, -1);                  // reset in DRAIN, no done
`ifdef LOOP_SEQ_STALL_EN
    stall_at = 6;
    stall_len = 3;
    run_job(1, 1, 3, 18);                  // 3-cycle stall mid-FEED
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
